// File: rtl/activation_pipe.sv
// activation_pipe
// ----------------------------------------------------------------------------
// Streams LANES-wide signed vectors through a per-lane activation function.
// A start pulse begins a run of num_vectors vectors. The run configuration
// (act_mode, leak_shift, clip_max, num_vectors) is captured on that start.
// Data passes through two register stages:
//   S1 : activation result, already masked by validity_mask
//   S2 : output register driving out_valid / out_data
// Both stages advance together whenever S2 is empty or being consumed. They
// freeze as a unit while out_valid & !out_ready.
//
// Optional feature macro: ACTIVATION_PIPE_LEAKY_EN
//   defined   : act_mode 2'b10 is leaky ReLU (x < 0 -> x >>> leak_shift)
//   undefined : act_mode 2'b10 behaves as plain ReLU, leak_shift is ignored
//
// Ports
//   clk             : clock, rising edge
//   reset           : synchronous active-high reset
//   start           : one-cycle pulse, starts a run (ignored while running)
//   act_mode        : 00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU
//   leak_shift      : arithmetic shift applied to negative leaky inputs
//   clip_max        : upper saturation limit for clipped ReLU (signed)
//   num_vectors     : number of vectors in the run
//   in_valid/in_ready, inp_data, validity_mask : input handshake + payload
//   out_valid/out_ready, out_data              : output handshake + payload
//   done_activation : high while the run is complete (DONE state)
// ----------------------------------------------------------------------------
module activation_pipe #(
    parameter int LANES  = 4,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              act_mode,
    input  logic [2:0]              leak_shift,
    input  logic [DWIDTH-1:0]       clip_max,
    input  logic [CWIDTH-1:0]       num_vectors,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DWIDTH-1:0] inp_data,
    input  logic [LANES-1:0]        validity_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DWIDTH-1:0] out_data,
    output logic                    done_activation
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [DWIDTH-1:0]       cmax_q, cmax_d;
    logic [CWIDTH-1:0]       nv_q, nv_d;
    logic [CWIDTH-1:0]       in_cnt_q, in_cnt_d;
    logic [CWIDTH-1:0]       out_cnt_q, out_cnt_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [LANES*DWIDTH-1:0] s1_data_q, s1_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [LANES*DWIDTH-1:0] out_data_q, out_data_d;
    logic                    done_q, done_d;

    logic                    advance_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic                    out_hs_s;
    logic                    start_acc_s;
    logic [LANES*DWIDTH-1:0] lanes_s;

`ifdef ACTIVATION_PIPE_LEAKY_EN
    logic [2:0]              shift_q, shift_d;
`else
    logic                    leak_unused_s;
    assign leak_unused_s = ^leak_shift;
`endif

    // Per-lane activation; x and cmax are treated as two's complement.
    function automatic logic [DWIDTH-1:0] act_lane(
        input logic signed [DWIDTH-1:0] x,
        input logic [1:0]               mode,
`ifdef ACTIVATION_PIPE_LEAKY_EN
        input logic [2:0]               sh,
`endif
        input logic signed [DWIDTH-1:0] cmax
    );
        logic [DWIDTH-1:0] r;
        case (mode)
            2'b00: r = x;
            2'b01: r = x[DWIDTH-1] ? {DWIDTH{1'b0}} : x;
`ifdef ACTIVATION_PIPE_LEAKY_EN
            2'b10: r = x[DWIDTH-1] ? (x >>> sh) : x;
`else
            2'b10: r = x[DWIDTH-1] ? {DWIDTH{1'b0}} : x;
`endif
            2'b11: begin
                if (x[DWIDTH-1]) begin
                    r = {DWIDTH{1'b0}};
                end else if (x > cmax) begin
                    r = cmax;
                end else begin
                    r = x;
                end
            end
            default: r = x;
        endcase
        return r;
    endfunction

    // Handshake qualifiers shared by the FSM, counters and datapath.
    assign advance_s   = ~out_valid_q | out_ready;
    assign out_hs_s    = out_valid_q & out_ready;
    assign start_acc_s = start & (state_q != ST_RUN);
    assign accept_s    = in_valid & in_ready_s;

    // FSM next-state: a run ends on the handshake of its last vector.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (nv_q == {CWIDTH{1'b0}}) begin
                    state_d = ST_DONE;
                end else if (out_hs_s && ((out_cnt_q + CWIDTH'(1)) == nv_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: input acceptance window and next value of the done flag.
    always_comb begin
        in_ready_s = 1'b0;
        done_d     = 1'b0;
        if (state_q == ST_RUN) begin
            in_ready_s = (in_cnt_q < nv_q) & advance_s;
        end else begin
            in_ready_s = 1'b0;
        end
        done_d = (state_d == ST_DONE);
    end

    // Run configuration and vector counters, refreshed on an accepted start.
    always_comb begin
        mode_d    = mode_q;
        cmax_d    = cmax_q;
        nv_d      = nv_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
`ifdef ACTIVATION_PIPE_LEAKY_EN
        shift_d   = shift_q;
`endif
        if (start_acc_s) begin
            mode_d    = act_mode;
            cmax_d    = clip_max;
            nv_d      = num_vectors;
            in_cnt_d  = {CWIDTH{1'b0}};
            out_cnt_d = {CWIDTH{1'b0}};
`ifdef ACTIVATION_PIPE_LEAKY_EN
            shift_d   = leak_shift;
`endif
        end else begin
            if (accept_s) in_cnt_d = in_cnt_q + CWIDTH'(1);
            else          in_cnt_d = in_cnt_q;
            if (out_hs_s) out_cnt_d = out_cnt_q + CWIDTH'(1);
            else          out_cnt_d = out_cnt_q;
        end
    end

    // Lane compute with the captured configuration; masked lanes become zero.
    always_comb begin
        lanes_s = {(LANES*DWIDTH){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (validity_mask[i]) begin
`ifdef ACTIVATION_PIPE_LEAKY_EN
                lanes_s[i*DWIDTH +: DWIDTH] = act_lane($signed(inp_data[i*DWIDTH +: DWIDTH]),
                                                       mode_q, shift_q, $signed(cmax_q));
`else
                lanes_s[i*DWIDTH +: DWIDTH] = act_lane($signed(inp_data[i*DWIDTH +: DWIDTH]),
                                                       mode_q, $signed(cmax_q));
`endif
            end else begin
                lanes_s[i*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
            end
        end
    end

    // Two-stage datapath; both stages move together or both hold. Empty
    // stages carry zero data so out_data reads zero whenever out_valid is low.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (advance_s) begin
            s1_valid_d  = accept_s;
            s1_data_d   = accept_s ? lanes_s : {(LANES*DWIDTH){1'b0}};
            out_valid_d = s1_valid_q;
            out_data_d  = s1_valid_q ? s1_data_q : {(LANES*DWIDTH){1'b0}};
        end else begin
            s1_valid_d  = s1_valid_q;
            s1_data_d   = s1_data_q;
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
    end

    // State, configuration, counters and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'b00;
            cmax_q      <= {DWIDTH{1'b0}};
            nv_q        <= {CWIDTH{1'b0}};
            in_cnt_q    <= {CWIDTH{1'b0}};
            out_cnt_q   <= {CWIDTH{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_data_q   <= {(LANES*DWIDTH){1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {(LANES*DWIDTH){1'b0}};
            done_q      <= 1'b0;
`ifdef ACTIVATION_PIPE_LEAKY_EN
            shift_q     <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cmax_q      <= cmax_d;
            nv_q        <= nv_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
`ifdef ACTIVATION_PIPE_LEAKY_EN
            shift_q     <= shift_d;
`endif
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign done_activation = done_q;

endmodule

// File: tb/tb_activation_pipe.sv
// Self-checking bench for activation_pipe (LANES=4, DWIDTH=8, CWIDTH=16).
// Driver pushes expected vectors into a scoreboard on acceptance; a negedge
// monitor pops and compares on every output handshake, and also checks
// stall stability and zero data while out_valid is low.
module tb_activation_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  act_mode;
    logic [2:0]  leak_shift;
    logic [7:0]  clip_max;
    logic [15:0] num_vectors;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inp_data;
    logic [3:0]  validity_mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        done_activation;

    activation_pipe #(.LANES(4), .DWIDTH(8), .CWIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .act_mode(act_mode),
        .leak_shift(leak_shift), .clip_max(clip_max), .num_vectors(num_vectors),
        .in_valid(in_valid), .in_ready(in_ready), .inp_data(inp_data),
        .validity_mask(validity_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .done_activation(done_activation)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    bit          lat_q[$];
    int          rdy_mode = 0;   // 0 high, 1 random, 2 low

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    // Reference: the activation rules applied with integer arithmetic.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [3:0] m,
                                          input int mode, input int sh, input int cmax);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int x;
            int y;
            int dv;
            logic [7:0] b;
            b = d[i*8 +: 8];
            x = int'($signed(b));
            case (mode)
                0: y = x;
                1: y = (x < 0) ? 0 : x;
                2: begin
`ifdef ACTIVATION_PIPE_LEAKY_EN
                    if (x >= 0) y = x;
                    else begin
                        dv = 1 << sh;
                        y = x / dv;
                        if ((x % dv) != 0) y = y - 1;
                    end
`else
                    dv = sh;
                    y = (x < 0) ? 0 : x;
`endif
                end
                default: y = (x < 0) ? 0 : ((x > cmax) ? cmax : x);
            endcase
            if (!m[i]) y = 0;
            r[i*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    // out_ready generator, settles 2 time units after each rising edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard compare, latency, stall stability, idle zero data.
    logic [31:0] prev_data = '0;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", 32'(out_valid), 32'd1);
                chk("stall_data_held", out_data, prev_data);
            end
            if (!out_valid) chk("idle_data_zero", out_data, 32'd0);
            if (out_valid && !out_ready) chk("in_ready_in_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %h, nothing expected", out_data);
                end else begin
                    logic [31:0] e;
                    int a;
                    bit l;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    l = lat_q.pop_front();
                    chk("out_data", out_data, e);
                    if (l) chk("latency_cycle", 32'(cyc), 32'(a + 1));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Pulse start with a configuration, then scramble the config inputs.
    task automatic do_start(input int mode, input int sh, input int cmax, input int nv);
        act_mode    = 2'(mode);
        leak_shift  = 3'(sh);
        clip_max    = 8'(cmax);
        num_vectors = 16'(nv);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        act_mode    = 2'($urandom);
        leak_shift  = 3'($urandom);
        clip_max    = 8'($urandom);
        num_vectors = 16'($urandom);
    endtask

    // Offer one vector until accepted; expected response queued on acceptance.
    task automatic send(input logic [31:0] d, input logic [3:0] m, input logic [31:0] e, input bit lat);
        int tries;
        tries = 0;
        in_valid      = 1'b1;
        inp_data      = d;
        validity_mask = m;
        forever begin
            #3;
            if (in_ready) begin
                exp_q.push_back(e);
                acc_q.push_back(cyc + 1);
                lat_q.push_back(lat);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            tries++;
            if (tries > 60) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait for the scoreboard to drain, then done must be high.
    task automatic wait_done(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (i >= bound) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d vectors pending, expected 0", exp_q.size());
        end
        chk("done_after_last", 32'(done_activation), 32'd1);
    endtask

    task automatic do_reset();
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        in_valid = 1'b0;
        start    = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_done", 32'(done_activation), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; inp_data = '0; validity_mask = '0;
        act_mode = '0; leak_shift = '0; clip_max = '0; num_vectors = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("init_in_ready", 32'(in_ready), 32'd0);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_data", out_data, 32'd0);
        chk("init_done", 32'(done_activation), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // ReLU, two vectors, out_ready held high, latency checked.
        rdy_mode = 0;
        do_start(1, 0, 0, 2);
        send(pk(-5, 3, -128, 127), 4'b1111, pk(0, 3, 0, 127), 1'b1);
        send(pk(0, -1, 1, 64), 4'b1111, pk(0, 0, 1, 64), 1'b1);
        wait_done(20);

        // Leaky ReLU (falls back to ReLU without the feature).
        do_start(2, 2, 0, 1);
`ifdef ACTIVATION_PIPE_LEAKY_EN
        send(pk(-8, -1, 12, -128), 4'b1111, pk(-2, -1, 12, -32), 1'b1);
`else
        send(pk(-8, -1, 12, -128), 4'b1111, pk(0, 0, 12, 0), 1'b1);
`endif
        wait_done(20);

        // Clipped ReLU with a masked lane.
        do_start(3, 0, 6, 1);
        send(pk(7, -3, 6, 100), 4'b1011, pk(6, 0, 0, 6), 1'b1);
        wait_done(20);

        // Stream of 4 with a 3-cycle out_ready stall in the middle.
        do_start(0, 0, 0, 4);
        fork
            begin
                send(pk(1, 2, 3, 4), 4'b1111, pk(1, 2, 3, 4), 1'b0);
                send(pk(5, 6, 7, 8), 4'b1111, pk(5, 6, 7, 8), 1'b0);
                send(pk(-9, 10, -11, 12), 4'b1111, pk(-9, 10, -11, 12), 1'b0);
                send(pk(13, -14, 15, -16), 4'b0110, pk(0, -14, 15, 0), 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy_mode = 2;
                repeat (3) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        wait_done(40);

        // Randomized runs with random back-pressure and input gaps.
        for (int run = 0; run < 10; run++) begin
            int mode, sh, cmax, nv;
            mode = $urandom_range(0, 3);
            sh   = $urandom_range(0, 7);
            cmax = $urandom_range(0, 127);
            nv   = $urandom_range(1, 6);
            rdy_mode = 1;
            do_start(mode, sh, cmax, nv);
            for (int k = 0; k < nv; k++) begin
                logic [31:0] d;
                logic [3:0]  m;
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                d = $urandom;
                m = 4'($urandom);
                send(d, m, model(d, m, mode, sh, cmax), 1'b0);
            end
            wait_done(200);
        end

        // Reset with two vectors in flight: nothing may emerge afterwards.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        do_start(0, 0, 0, 3);
        send(pk(21, 22, 23, 24), 4'b1111, pk(21, 22, 23, 24), 1'b0);
        send(pk(31, 32, 33, 34), 4'b1111, pk(31, 32, 33, 34), 1'b0);
        @(posedge clk);
        #1;
        do_reset();
        rdy_mode = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("post_reset_no_valid", 32'(out_valid), 32'd0);
        end

        // Fresh run of one vector after the reset.
        do_start(1, 0, 0, 1);
        send(pk(-1, 50, -60, 70), 4'b1101, pk(0, 0, 0, 70), 1'b1);
        wait_done(20);

        // Zero-length run: RUN for one cycle, then DONE.
        do_start(1, 0, 0, 0);
        chk("nv0_run_cycle_done", 32'(done_activation), 32'd0);
        chk("nv0_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("nv0_done", 32'(done_activation), 32'd1);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/activation_pipe.md
ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel data lanes.
REQ-002 SHALL have parameter DWIDTH, default 8, two's-complement width of each lane.
REQ-003 SHALL have parameter CWIDTH, default 16, width of the vector counter and num_vectors.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse that begins a run.
REQ-007 SHALL have port act_mode  input  2  00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU.
REQ-008 SHALL have port leak_shift  input  3  arithmetic right-shift amount for negative leaky-ReLU inputs.
REQ-009 SHALL have port clip_max  input  DWIDTH  positive saturation limit for clipped ReLU.
REQ-010 SHALL have port num_vectors  input  CWIDTH  vectors to emit per run.
REQ-011 SHALL have ports in_valid input 1, in_ready output 1, inp_data input LANES*DWIDTH, validity_mask input LANES (lane i at inp_data[(i+1)*DWIDTH-1 -: DWIDTH]).
REQ-012 SHALL have ports out_valid output 1, out_ready input 1, out_data output LANES*DWIDTH.
REQ-013 SHALL have port done_activation  output  1  run complete.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE: IDLE/DONE + start -> RUN (counter cleared); RUN -> DONE the cycle the num_vectors-th output handshake (out_valid & out_ready) occurs; start in RUN ignored.
REQ-015 SHALL latch act_mode, leak_shift, clip_max, num_vectors on the accepted start; later changes have no effect until the next start.
REQ-016 SHALL, when start arrives with num_vectors = 0, go RUN -> DONE on the next cycle with no input accepted.
REQ-017 SHALL accept input when in_valid & in_ready; in_ready = (state==RUN) & (inputs accepted < num_vectors) & pipeline able to advance.
REQ-018 SHALL be a two-stage pipeline (S1 compute register, S2 output register); with out_ready held high, out_valid rises exactly 2 cycles after acceptance, sustaining one vector per cycle.
REQ-019 SHALL stall both stages when out_valid & !out_ready; out_data and out_valid hold stable; no data lost or duplicated.
REQ-020 SHALL compute per lane: bypass x; ReLU max(x,0); leaky x>=0 ? x : x>>>leak_shift; clipped x<0 ? 0 : min(x, clip_max) (signed compare).
REQ-021 SHALL force output lane to zero where the validity_mask bit captured with that vector is 0, in every mode.
REQ-022 SHALL hold done_activation high throughout DONE and low otherwise.
REQ-023 SHALL hold out_data at zero whenever out_valid is low.

Reset
REQ-024 SHALL, on reset, enter IDLE, clear counters, all pipeline valids, out_data, done_activation; in_ready and out_valid are 0 in the cycle after reset.
REQ-025 SHALL, on reset mid-run, discard in-flight vectors; none emerge afterward.
REQ-026 SHALL give reset priority over start in the same cycle.

Configuration
REQ-027 SHALL compile leaky ReLU only when ACTIVATION_PIPE_LEAKY_EN is defined; otherwise act_mode 10 behaves exactly as ReLU (01) and leak_shift is unused.

Verification
REQ-028 SHALL cover: start, mode 01, num_vectors 2, inputs {-5,3,-128,127}, {0,-1,1,64}, mask 4'b1111, out_ready=1 -> outputs {0,3,0,127}, {0,0,1,64} at +2 cycles each, done_activation high the cycle after 2nd handshake.
REQ-029 SHALL cover: mode 10, leak_shift 2, input {-8,-1,12,-128} with macro defined -> {-2,-1,12,-32}; without macro -> {0,0,12,0}.
REQ-030 SHALL cover: mode 11, clip_max 6, input {7,-3,6,100}, mask 4'b1011 -> {6,0,0,6}.
REQ-031 SHALL cover: 4 vectors streamed, out_ready low for 3 cycles mid-stream -> out_data stable during stall, all 4 vectors in order, in_ready low while stalled.
REQ-032 SHALL cover: reset asserted with 2 vectors in flight -> no out_valid after reset; new start with num_vectors 1 completes normally; num_vectors 0 -> done_activation high one cycle after start.
